service_scheduler: RTL and testbench

//  Arbiter/sequencer for the alarm-clock top level. Owns the shared 7-segment datapath and push buttons.

---
 rtl/service_scheduler_pkg.sv | 41 ++++
 rtl/service_scheduler_if.sv | 31 +++
 rtl/service_sel_filter.sv | 50 +++++
 rtl/service_scheduler.sv | 156 +++++++++++++++
 tb/tb_service_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/service_scheduler_pkg.sv
// Shared state encodings, service one-hot constants and small decode helpers
// for the alarm-clock service scheduler.
package service_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] SERVICE1     = 4'b1000;
    localparam logic [3:0] SERVICE2     = 4'b0100;
    localparam logic [3:0] SERVICE3     = 4'b0010;
    localparam logic [3:0] SERVICE4     = 4'b0001;
    localparam logic [3:0] SERVICERESET = 4'b0000;

    function automatic logic [3:0] svc_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = SERVICE1;
            2'd1:    oh = SERVICE2;
            2'd2:    oh = SERVICE3;
            default: oh = SERVICE4;
        endcase
        return oh;
    endfunction

    // Service 1 owns the most significant digit group.
    function automatic logic [15:0] svc_digits(input logic [63:0] num, input logic [1:0] idx);
        logic [15:0] d;
        case (idx)
            2'd0:    d = num[63:48];
            2'd1:    d = num[47:32];
            2'd2:    d = num[31:16];
            default: d = num[15:0];
        endcase
        return d;
    endfunction

endpackage

// File: rtl/service_scheduler_if.sv
// Bundle of the scheduler's service, alarm and display signals.
interface service_scheduler_if;

    logic        tick_1hz;
    logic [3:0]  spdt_service;
    logic [3:0]  finish;
    logic        alarm_match;
    logic        game_done;
    logic        push_m;
    logic [63:0] num_svc;
    logic [15:0] current_time;
    logic [3:0]  grant;
    logic [3:0]  svc_led;
    logic [15:0] disp_num;
    logic        disp_blank;
    logic        alarm_active;
    logic        game_en;

    modport master (
        output tick_1hz, spdt_service, finish, alarm_match, game_done, push_m,
               num_svc, current_time,
        input  grant, svc_led, disp_num, disp_blank, alarm_active, game_en
    );

    modport slave (
        input  tick_1hz, spdt_service, finish, alarm_match, game_done, push_m,
               num_svc, current_time,
        output grant, svc_led, disp_num, disp_blank, alarm_active, game_en
    );

endinterface

// File: rtl/service_sel_filter.sv
// Mode-switch filter: a one-hot selection must sit unchanged for SEL_STABLE
// cycles before it is reported as valid.
module service_sel_filter
    import service_scheduler_pkg::*;
#(
    parameter logic [3:0] SEL_STABLE = 4'd8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] spdt_service,
    output logic       sel_ok,
    output logic [1:0] sel_idx
);

    logic [3:0] prev;
    logic [3:0] sel_cnt;
    logic       one_hot;
    logic       stable;

    assign one_hot = $onehot(spdt_service);
    assign stable  = (spdt_service == prev);

    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= '0;
            sel_cnt <= '0;
        end else begin
            prev <= spdt_service;
            if (!one_hot || !stable)
                sel_cnt <= '0;
            else if (sel_cnt != SEL_STABLE - 4'd1)
                sel_cnt <= sel_cnt + 4'd1;
        end
    end

    // stable is included so a saturated count never validates a fresh change.
    assign sel_ok = one_hot && stable && (sel_cnt == SEL_STABLE - 4'd1);

    always_comb begin
        sel_idx = 2'd0;
        case (spdt_service)
            SERVICE1: sel_idx = 2'd0;
            SERVICE2: sel_idx = 2'd1;
            SERVICE3: sel_idx = 2'd2;
            SERVICE4: sel_idx = 2'd3;
            default:  sel_idx = 2'd0;
        endcase
    end

endmodule

// File: rtl/service_scheduler.sv
// Service arbiter/sequencer: grants one service from the mode switches, muxes
// its digits to the display and pre-empts everything while the alarm rings.
module service_scheduler
    import service_scheduler_pkg::*;
#(
    parameter logic [3:0] SEL_STABLE    = 4'd8,
    parameter logic [7:0] ALARM_TIMEOUT = 8'd60
) (
    input logic                 clk,
    input logic                 reset,
    service_scheduler_if.slave  bus
);

    state_t      state;
    state_t      ret_state;
    logic [1:0]  cur_svc;
    logic [1:0]  ret_svc;
    logic [7:0]  to_cnt;
    logic        match_q;
    logic        push_q;
    logic        sel_ok;
    logic [1:0]  sel_idx;

    logic [3:0]  grant_q;
    logic [3:0]  svc_led_q;
    logic [15:0] disp_num_q;
    logic        disp_blank_q;
    logic        alarm_active_q;
    logic        game_en_q;

    logic        alarm_rise;
    logic        push_rise;
    logic        svc_finish;
    logic        alarm_exit;

    service_sel_filter #(.SEL_STABLE(SEL_STABLE)) u_sel_filter (
        .clk          (clk),
        .reset        (reset),
        .spdt_service (bus.spdt_service),
        .sel_ok       (sel_ok),
        .sel_idx      (sel_idx)
    );

    assign alarm_rise = bus.alarm_match & ~match_q;
    assign push_rise  = bus.push_m & ~push_q;
    assign svc_finish = (bus.finish & svc_onehot(cur_svc)) != '0;
    assign alarm_exit = bus.game_done | push_rise |
                        (bus.tick_1hz && to_cnt == ALARM_TIMEOUT - 8'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            ret_state      <= ST_IDLE;
            cur_svc        <= '0;
            ret_svc        <= '0;
            to_cnt         <= '0;
            // Edge detectors load the live level so a held alarm cannot re-fire.
            match_q        <= bus.alarm_match;
            push_q         <= bus.push_m;
            grant_q        <= '0;
            svc_led_q      <= '0;
            disp_num_q     <= '0;
            disp_blank_q   <= 1'b1;
            alarm_active_q <= 1'b0;
            game_en_q      <= 1'b0;
        end else begin
            match_q <= bus.alarm_match;
            push_q  <= bus.push_m;
            if (alarm_rise) begin
                if (state != ST_ALARM) begin
                    ret_state <= (state == ST_RUN && svc_finish) ? ST_DONE : state;
                    ret_svc   <= cur_svc;
                end
                state          <= ST_ALARM;
                to_cnt         <= '0;
                grant_q        <= '0;
                svc_led_q      <= '0;
                disp_num_q     <= bus.current_time;
                disp_blank_q   <= 1'b0;
                alarm_active_q <= 1'b1;
                game_en_q      <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (sel_ok) begin
                            state        <= ST_RUN;
                            cur_svc      <= sel_idx;
                            grant_q      <= svc_onehot(sel_idx);
                            svc_led_q    <= svc_onehot(sel_idx);
                            disp_num_q   <= svc_digits(bus.num_svc, sel_idx);
                            disp_blank_q <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        disp_num_q <= svc_digits(bus.num_svc, cur_svc);
                        if (svc_finish) begin
                            state     <= ST_DONE;
                            grant_q   <= '0;
                            svc_led_q <= '0;
                        end else if (bus.spdt_service != grant_q) begin
                            state        <= ST_IDLE;
                            grant_q      <= '0;
                            svc_led_q    <= '0;
                            disp_blank_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (bus.spdt_service == SERVICERESET) begin
                            state        <= ST_IDLE;
                            disp_blank_q <= 1'b1;
                        end
                    end
                    ST_ALARM: begin
                        disp_num_q <= bus.current_time;
                        if (bus.tick_1hz) begin
                            disp_blank_q <= ~disp_blank_q;
                            if (to_cnt != '1)
                                to_cnt <= to_cnt + 8'd1;
                        end
                        if (alarm_exit) begin
                            alarm_active_q <= 1'b0;
                            game_en_q      <= 1'b0;
                            if (ret_state == ST_RUN &&
                                bus.spdt_service == svc_onehot(ret_svc)) begin
                                state        <= ST_RUN;
                                cur_svc      <= ret_svc;
                                grant_q      <= svc_onehot(ret_svc);
                                svc_led_q    <= svc_onehot(ret_svc);
                                disp_num_q   <= svc_digits(bus.num_svc, ret_svc);
                                disp_blank_q <= 1'b0;
                            end else if (ret_state == ST_DONE) begin
                                state        <= ST_DONE;
                                disp_blank_q <= 1'b0;
                            end else begin
                                state        <= ST_IDLE;
                                disp_blank_q <= 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.grant        = grant_q;
    assign bus.svc_led      = svc_led_q;
    assign bus.disp_num     = disp_num_q;
    assign bus.disp_blank   = disp_blank_q;
    assign bus.alarm_active = alarm_active_q;
    assign bus.game_en      = game_en_q;

    grant_safe: assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant_q) && !(alarm_active_q && grant_q != '0));

endmodule

// File: tb/tb_service_scheduler.sv
// Directed scoreboard bench for service_scheduler.
module tb_service_scheduler;

    logic clk = 1'b0;
    logic reset;

    service_scheduler_if bus ();

    service_scheduler #(.SEL_STABLE(4'd8), .ALARM_TIMEOUT(8'd60)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    localparam logic [63:0] NUM  = 64'h1201_3459_0717_2358;
    localparam logic [15:0] TIME = 16'h0730;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed %0h expected none", obs);
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        push(tag, exp);
        pop_check(obs);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_pulse();
        bus.tick_1hz = 1'b1;
        step(1);
        bus.tick_1hz = 1'b0;
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_grant"},   32'(bus.grant),        32'h0);
        chk({pfx, "_led"},     32'(bus.svc_led),      32'h0);
        chk({pfx, "_disp"},    32'(bus.disp_num),     32'h0);
        chk({pfx, "_blank"},   32'(bus.disp_blank),   32'h1);
        chk({pfx, "_alarm"},   32'(bus.alarm_active), 32'h0);
        chk({pfx, "_game_en"}, 32'(bus.game_en),      32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset            = 1'b1;
        bus.tick_1hz     = 1'b0;
        bus.spdt_service = 4'b0000;
        bus.finish       = 4'b0000;
        bus.alarm_match  = 1'b0;
        bus.game_done    = 1'b0;
        bus.push_m       = 1'b0;
        bus.num_svc      = NUM;
        bus.current_time = TIME;
        step(3);
        check_reset_vals("rst");

        // Test 1: svc2 granted exactly SEL_STABLE+1 edges after the switch change
        reset = 1'b0;
        bus.spdt_service = 4'b0100;
        step(8);
        chk("t1_grant_early", 32'(bus.grant), 32'h0);
        step(1);
        chk("t1_grant", 32'(bus.grant),      32'h4);
        chk("t1_led",   32'(bus.svc_led),    32'h4);
        chk("t1_disp",  32'(bus.disp_num),   32'h3459);
        chk("t1_blank", 32'(bus.disp_blank), 32'h0);

        // Test 2: two switches up aborts and never grants
        bus.spdt_service = 4'b1100;
        step(1);
        chk("t2_abort", 32'(bus.grant), 32'h0);
        step(50);
        chk("t2_grant", 32'(bus.grant),      32'h0);
        chk("t2_blank", 32'(bus.disp_blank), 32'h1);

        // Test 3: finish on svc1, DONE until switches cleared, then svc2
        bus.spdt_service = 4'b1000;
        step(9);
        chk("t3_grant", 32'(bus.grant),    32'h8);
        chk("t3_disp",  32'(bus.disp_num), 32'h1201);
        bus.finish = 4'b0100;
        step(1);
        bus.finish = 4'b0000;
        chk("t3_other_finish", 32'(bus.grant), 32'h8);
        bus.finish = 4'b1000;
        step(1);
        bus.finish = 4'b0000;
        chk("t3_done_led",   32'(bus.svc_led),    32'h0);
        chk("t3_done_grant", 32'(bus.grant),      32'h0);
        chk("t3_done_blank", 32'(bus.disp_blank), 32'h0);
        chk("t3_done_disp",  32'(bus.disp_num),   32'h1201);
        step(20);
        chk("t3_done_hold", 32'(bus.svc_led), 32'h0);
        bus.spdt_service = 4'b0000;
        step(1);
        chk("t3_idle_blank", 32'(bus.disp_blank), 32'h1);
        bus.spdt_service = 4'b0100;
        step(9);
        chk("t3_svc2", 32'(bus.grant), 32'h4);

        // Test 4: alarm pre-empts svc3, game_done returns to svc3
        bus.spdt_service = 4'b0010;
        step(10);
        chk("t4_grant", 32'(bus.grant), 32'h2);
        bus.alarm_match = 1'b1;
        step(1);
        chk("t4_alarm",   32'(bus.alarm_active), 32'h1);
        chk("t4_grant0",  32'(bus.grant),        32'h0);
        chk("t4_game_en", 32'(bus.game_en),      32'h1);
        chk("t4_disp",    32'(bus.disp_num),     32'(TIME));
        bus.game_done = 1'b1;
        step(1);
        bus.game_done = 1'b0;
        chk("t4_ret_grant", 32'(bus.grant),        32'h2);
        chk("t4_ret_alarm", 32'(bus.alarm_active), 32'h0);
        chk("t4_ret_disp",  32'(bus.disp_num),     32'h0717);
        step(5);
        chk("t4_no_retrig", 32'(bus.alarm_active), 32'h0);
        bus.alarm_match = 1'b0;
        step(1);

        // Test 5: timeout after 60 ticks, switch changed -> IDLE
        bus.alarm_match = 1'b1;
        step(1);
        chk("t5_alarm", 32'(bus.alarm_active), 32'h1);
        bus.spdt_service = 4'b0000;
        tick_pulse();
        chk("t5_blink", 32'(bus.disp_blank), 32'h1);
        step(1);
        for (int i = 0; i < 58; i++) begin
            tick_pulse();
            step(1);
        end
        chk("t5_tick59", 32'(bus.alarm_active), 32'h1);
        tick_pulse();
        chk("t5_timeout", 32'(bus.alarm_active), 32'h0);
        chk("t5_grant",   32'(bus.grant),        32'h0);
        chk("t5_game_en", 32'(bus.game_en),      32'h0);
        bus.alarm_match = 1'b0;
        step(1);

        // push_m rising edge dismisses an alarm raised from IDLE
        bus.alarm_match = 1'b1;
        step(1);
        chk("pm_alarm", 32'(bus.alarm_active), 32'h1);
        bus.push_m = 1'b1;
        step(1);
        chk("pm_exit",  32'(bus.alarm_active), 32'h0);
        chk("pm_blank", 32'(bus.disp_blank),   32'h1);
        bus.push_m = 1'b0;
        bus.alarm_match = 1'b0;
        step(1);

        // Test 6: reset while ringing, held alarm_match must not re-enter
        bus.alarm_match = 1'b1;
        step(1);
        chk("t6_alarm", 32'(bus.alarm_active), 32'h1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_reset_vals("t6");
        step(5);
        chk("t6_no_reentry", 32'(bus.alarm_active), 32'h0);
        bus.alarm_match = 1'b0;
        step(1);
        bus.alarm_match = 1'b1;
        step(1);
        chk("t6_reentry", 32'(bus.alarm_active), 32'h1);
        bus.game_done = 1'b1;
        step(1);
        bus.game_done = 1'b0;
        bus.alarm_match = 1'b0;
        step(1);

        // finish and alarm rise together: alarm wins, returns to DONE
        bus.spdt_service = 4'b0001;
        step(9);
        chk("sim_grant", 32'(bus.grant),    32'h1);
        chk("sim_disp",  32'(bus.disp_num), 32'h2358);
        bus.finish = 4'b0001;
        bus.alarm_match = 1'b1;
        step(1);
        bus.finish = 4'b0000;
        chk("sim_alarm", 32'(bus.alarm_active), 32'h1);
        bus.game_done = 1'b1;
        step(1);
        bus.game_done = 1'b0;
        chk("sim_done_grant", 32'(bus.grant),        32'h0);
        chk("sim_done_led",   32'(bus.svc_led),      32'h0);
        chk("sim_done_blank", 32'(bus.disp_blank),   32'h0);
        chk("sim_done_alarm", 32'(bus.alarm_active), 32'h0);
        step(10);
        chk("sim_done_hold", 32'(bus.grant), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
